// File: rtl/regfile_wr_arbiter.sv
// Shares the single register-file write port between pipeline writeback and a small
// FIFO of long-latency results, and tracks pending long-latency destinations.
module regfile_wr_arbiter #(
    parameter int DATA_W     = 64,
    parameter int FIFO_DEPTH = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic              clk_i,
    input  logic              reset_i,
    input  logic              w_valid_i,
    input  logic              w_wen_i,
    input  logic [4:0]        w_dst_i,
    input  logic [DATA_W-1:0] w_data_i,
    output logic              w_stall_o,
    input  logic              l_valid_i,
    output logic              l_ready_o,
    input  logic [4:0]        l_dst_i,
    input  logic [DATA_W-1:0] l_data_i,
    input  logic              issue_valid_i,
    input  logic [4:0]        issue_dst_i,
    output logic [31:0]       busy_o,
    output logic              rf_wen_o,
    output logic [4:0]        rf_wa_o,
    output logic [DATA_W-1:0] rf_wd_o
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [CW-1:0] DEPTH_C  = CW'(FIFO_DEPTH);
    localparam logic [SW-1:0] STARVE_C = SW'(STARVE_MAX);

    logic [4:0]        dst_q  [FIFO_DEPTH];
    logic [DATA_W-1:0] data_q [FIFO_DEPTH];
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CW-1:0]     count_q, count_d;
    logic [SW-1:0]     starve_q, starve_d;
    logic [31:0]       busy_q, busy_d;

    logic w_req;
    logic fifo_ne;
    logic grant_l;
    logic grant_w;
    logic push;
    logic [4:0] head_dst;

    always_comb begin
        head_dst  = dst_q[rd_ptr_q];
        w_req     = w_valid_i & w_wen_i & (w_dst_i != 5'd0);
        fifo_ne   = (count_q != '0);
        // l_ready looks only at registered occupancy; a same-cycle pop never frees a slot
        l_ready_o = reset_i & (count_q < DEPTH_C);
        grant_l   = reset_i & fifo_ne & (~w_req | (starve_q == STARVE_C));
        grant_w   = reset_i & w_req & ~grant_l;
        push      = l_valid_i & l_ready_o & (l_dst_i != 5'd0);

        rf_wen_o  = grant_l | grant_w;
        rf_wa_o   = grant_l ? head_dst : w_dst_i;
        rf_wd_o   = grant_l ? data_q[rd_ptr_q] : w_data_i;
        w_stall_o = grant_l & w_req;

        rd_ptr_d  = grant_l ? rd_ptr_q + PW'(1) : rd_ptr_q;
        wr_ptr_d  = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
        count_d   = count_q + CW'(push) - CW'(grant_l);

        starve_d = starve_q;
        if (!fifo_ne || grant_l) begin
            starve_d = '0;
        end else if (starve_q < STARVE_C) begin
            starve_d = starve_q + SW'(1);
        end

        // Clear first so a same-cycle issue to the written register wins
        busy_d = busy_q;
        if (grant_l) begin
            busy_d[head_dst] = 1'b0;
        end
        if (reset_i && issue_valid_i) begin
            busy_d[issue_dst_i] = 1'b1;
        end
        busy_d[0] = 1'b0;
    end

    always_ff @(posedge clk_i) begin
        if (!reset_i) begin
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            count_q  <= '0;
            starve_q <= '0;
            busy_q   <= '0;
        end else begin
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
            starve_q <= starve_d;
            busy_q   <= busy_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            dst_q[wr_ptr_q]  <= l_dst_i;
            data_q[wr_ptr_q] <= l_data_i;
        end
    end

    assign busy_o = busy_q;

endmodule

// File: doc/regfile_wr_arbiter.md
# regfile_wr_arbiter

Arbiter and sequencer for the single integer register-file write port. It shares the port between the in-order pipeline writeback result and results returning from long-latency units (multiply/divide), which are buffered in a small FIFO. It also keeps a pending-destination scoreboard that the decode stage uses to stall on outstanding long-latency results. It sits between the writeback stage and the register file, and stalls writeback when the long-latency path must take the port.

## Interface
Parameters:
- DATA_W, 64, width of write data
- FIFO_DEPTH, 2, long-latency result buffer entries (power of two, ≥2)
- STARVE_MAX, 4, number of cycles a buffered result may be denied before it preempts writeback

Ports:
- clk  in  1  clock; all state updates on rising edge
- reset  in  1  synchronous, active-low (0 = reset)
- w_valid  in  1  writeback stage holds a valid instruction
- w_wen  in  1  that instruction writes a register
- w_dst  in  5  destination register
- w_data  in  DATA_W  writeback value
- w_stall  out  1  writeback lost the port this cycle; pipeline must hold W inputs unchanged
- l_valid  in  1  long-latency unit offers a result
- l_ready  out  1  result accepted when l_valid & l_ready
- l_dst  in  5  result destination
- l_data  in  DATA_W  result value
- issue_valid  in  1  a long-latency op is issued this cycle
- issue_dst  in  5  its destination
- busy  out  32  bit i set = register i has a pending long-latency result
- rf_wen  out  1  register-file write enable
- rf_wa  out  5  write address
- rf_wd  out  DATA_W  write data

## Operation
- W request: w_valid & w_wen & (w_dst != 0). Any other W input is ignored and never stalled.
- Enqueue: on l_valid & l_ready, push {l_dst, l_data}. l_dst == 0 is accepted but not stored. l_ready = (count < FIFO_DEPTH), computed from registered count only. A full FIFO does not accept a result even if a pop happens in the same cycle.
- Grant L: FIFO non-empty & (no W request | starve_cnt == STARVE_MAX). Otherwise grant W if W requests. Otherwise there is no write.
- Outputs: L grant drives rf_wen=1 with the head entry, pops the head, and sets w_stall = W request. W grant drives rf_wen=1 with {w_dst, w_data} and sets w_stall=0.
- starve_cnt: cleared when the FIFO is empty or on L grant. Otherwise, while the FIFO is non-empty and not granted, it increments and saturates at STARVE_MAX.
- Scoreboard: on issue_valid & issue_dst != 0, set busy[issue_dst]. On L grant, clear busy[rf_wa]. If set and clear hit the same register in the same cycle, set wins. Register 0 is never busy.
- Upstream contract: no issue to a register that is already busy, and no W write to a busy register. A bench assertion flags violations; the block behaviour is then unspecified.
- FIFO order is strict; results are written in acceptance order.

## Timing
- rf_wen/rf_wa/rf_wd and w_stall are combinational from the current inputs and registered state, so the write happens in the same cycle as writeback.
- A result accepted in cycle t is at the head, and eligible for write, in cycle t+1 at the earliest. There is no bypass.
- A busy bit set by issue in cycle t is visible in cycle t+1. A busy bit cleared by a write in cycle t reads 0 in cycle t+1.
- Worst-case wait for the FIFO head under continuous W traffic is STARVE_MAX+1 cycles.
- During and after reset (reset=0 sampled at an edge): FIFO empty, count=0, starve_cnt=0, busy=0. While reset is asserted, outputs are forced to rf_wen=0, w_stall=0, l_ready=0, and l/issue inputs are ignored. Reset mid-operation discards buffered results.

## Test plan
- Reset, then W writes x5=0x11 with no L traffic: rf_wen=1, rf_wa=5, rf_wd=0x11, w_stall=0 every cycle, busy=0.
- W with w_dst=0 or w_wen=0: rf_wen=0, w_stall=0. An L push with l_dst=0 is accepted, count stays 0, and no write occurs.
- issue x7 in cycle 0; L result x7=0xAB offered in cycle 3 with W idle: accepted in cycle 3, written in cycle 4, busy[7]=1 over cycles 1–4 and 0 from cycle 5.
- Continuous W requests plus one buffered L result, STARVE_MAX=4: W is granted for 4 cycles, then on the 5th cycle L is written with w_stall=1. In the next cycle the held W is written with w_stall=0.
- Fill the FIFO (2 results) while W is continuous: l_ready=0 while count=2. Results are written in order, and l_ready returns to 1 in the cycle after the first pop.
- Assert reset with 2 buffered results and busy≠0: the next cycle shows busy=0 and l_ready=0. After release, rf_wen stays 0 until new requests arrive.
